// File: rtl/ps2_keyboard_ctrl_if.sv
// ps2_keyboard_ctrl_if: consumer-side byte handshake of the PS/2 keyboard receiver.
interface ps2_keyboard_ctrl_if;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       nextdata_n;
    modport master (output data, output ready, output overflow, input nextdata_n);
    modport slave  (input data, input ready, input overflow, output nextdata_n);
endinterface

// File: rtl/ps2_keyboard_ctrl.sv
// ps2_keyboard_ctrl: PS/2 frame receiver feeding a small byte FIFO read via ready/nextdata_n.
module ps2_keyboard_ctrl #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    ps2_keyboard_ctrl_if.master   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [3:0]             r_cnt;
    logic [9:0]             r_buf;
    logic [7:0]             r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic                   r_ovf;

    logic w_fall;
    logic w_valid;
    logic w_empty;
    logic w_full;
    logic w_pop;

    assign w_fall  = r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES-2];
    // stop bit is the live pin value; parity is odd over data plus parity bit
    assign w_valid = w_fall && (r_cnt == 4'd10) && !r_buf[0] && ps2_data && (^r_buf[9:1]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = ((r_wptr + PTR_ONE) == r_rptr);
    assign w_pop   = !w_empty && !bus.nextdata_n;

    assign bus.data     = r_mem[r_rptr];
    assign bus.ready    = !w_empty;
    assign bus.overflow = r_ovf;

    always_ff @(posedge clk) begin
        if (clrn) begin
            r_sync <= '1;
            r_cnt  <= '0;
            r_buf  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ps2_clk};
            if (w_fall) begin
                if (r_cnt == 4'd10) begin
                    r_cnt <= '0;
                end else begin
                    r_buf[r_cnt] <= ps2_data;
                    r_cnt        <= r_cnt + 4'd1;
                end
            end
            // full is judged on pre-pop pointers, so a same-cycle pop cannot make room
            if (w_valid) begin
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_mem[r_wptr] <= r_buf[8:1];
                    r_wptr        <= r_wptr + PTR_ONE;
                end
            end
            if (w_pop) r_rptr <= r_rptr + PTR_ONE;
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// tb_ps2_keyboard_ctrl: directed PS/2 frames with hand-computed FIFO contents and flags.
module tb_ps2_keyboard_ctrl;
    logic clk = 1'b0;
    logic clrn = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    ps2_keyboard_ctrl_if bus ();

    ps2_keyboard_ctrl dut (
        .clk      (clk),
        .clrn     (clrn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            wait_clk(10);
            ps2_clk = 1'b0;
            wait_clk(20);
            ps2_clk = 1'b1;
            wait_clk(10);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        send_bits(f, 11);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b1;
        wait_clk(2);
        clrn = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        bus.nextdata_n = 1'b0;
        @(negedge clk);
        bus.nextdata_n = 1'b1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %02h expected %02h", name, act, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        wait_clk(100);
        chk("reset_ready", {7'd0, bus.ready}, 8'h00);
        chk("reset_data", bus.data, 8'h00);
        chk("reset_overflow", {7'd0, bus.overflow}, 8'h00);
    endtask

    task automatic test_single();
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("single_ready", {7'd0, bus.ready}, 8'h01);
        chk("single_data", bus.data, 8'h1C);
        pop();
        chk("single_ready_after_pop", {7'd0, bus.ready}, 8'h00);
    endtask

    task automatic test_back_to_back();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("b2b_first", bus.data, 8'hF0);
        pop();
        chk("b2b_second", bus.data, 8'h1C);
        pop();
        chk("b2b_empty", {7'd0, bus.ready}, 8'h00);
    endtask

    task automatic test_bad_frames();
        send_frame(8'h1C, 1'b1, 1'b0);
        chk("bad_parity_ready", {7'd0, bus.ready}, 8'h00);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("bad_stop_ready", {7'd0, bus.ready}, 8'h00);
        send_frame(8'h32, 1'b0, 1'b0);
        chk("good_after_bad_data", bus.data, 8'h32);
        chk("good_after_bad_ready", {7'd0, bus.ready}, 8'h01);
        chk("bad_no_overflow", {7'd0, bus.overflow}, 8'h00);
        pop();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 7; i++) send_frame(8'(i), 1'b0, 1'b0);
        chk("fill_ready", {7'd0, bus.ready}, 8'h01);
        chk("fill_overflow", {7'd0, bus.overflow}, 8'h00);
        send_frame(8'h08, 1'b0, 1'b0);
        chk("ovf_flag", {7'd0, bus.overflow}, 8'h01);
        chk("ovf_head", bus.data, 8'h01);
        for (int i = 1; i <= 7; i++) begin
            chk($sformatf("drain_%0d", i), bus.data, 8'(i));
            pop();
        end
        chk("drain_empty", {7'd0, bus.ready}, 8'h00);
        chk("ovf_sticky", {7'd0, bus.overflow}, 8'h01);
    endtask

    task automatic test_midframe_reset();
        send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5);
        do_reset();
        wait_clk(5);
        send_frame(8'h45, 1'b0, 1'b0);
        chk("mid_reset_data", bus.data, 8'h45);
        chk("mid_reset_ready", {7'd0, bus.ready}, 8'h01);
        chk("mid_reset_overflow", {7'd0, bus.overflow}, 8'h00);
        pop();
        @(negedge clk);
        bus.nextdata_n = 1'b0;
        wait_clk(5);
        bus.nextdata_n = 1'b1;
        chk("empty_pop_ready", {7'd0, bus.ready}, 8'h00);
        send_frame(8'h12, 1'b0, 1'b0);
        chk("empty_pop_next_data", bus.data, 8'h12);
        pop();
        chk("empty_pop_final", {7'd0, bus.ready}, 8'h00);
    endtask

    initial begin
        bus.nextdata_n = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_frames();
        test_overflow();
        test_midframe_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard_ctrl.md
Name: ps2_keyboard_ctrl

Overview:
- PS/2 keyboard receiver.
- Samples the keyboard's open-collector ps2_clk/ps2_data lines in the system clock domain and assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Pushes each valid scan-code byte into a small FIFO.
- Consumers read bytes through a ready/nextdata_n handshake; overflow flags lost data.

Parameters:
- FIFO_DEPTH, 8, number of FIFO storage entries (power of two, >=2); usable capacity is FIFO_DEPTH-1.
- SYNC_STAGES, 3, flops in the ps2_clk synchronizer/edge-detect history (>=3).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clrn  input  1  synchronous, active-high reset (the name is historical; polarity is active-high).
- ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous.
- ps2_data  input  1  raw PS/2 data from keyboard; sampled on detected ps2_clk falling edges.
- nextdata_n  input  1  active-low pop request; while low and ready high, one byte is consumed per clk.
- data  output  8  byte at FIFO head (combinational from storage at read pointer).
- ready  output  1  high while FIFO is non-empty.
- overflow  output  1  sticky flag; a valid byte arrived while FIFO was full.

Behaviour:
- Reset (clrn=1 at a clk edge):
  - bit counter=0, frame buffer=0, read/write pointers=0, FIFO storage cleared to 0.
  - overflow=0, synchronizer history all 1 (idle line).
  - Outputs after reset: ready=0, data=8'h00, overflow=0.
  - Reset mid-frame discards the partial frame.
- Synchronizer:
  - ps2_clk shifts into a SYNC_STAGES-bit history each clk.
  - Falling edge is detected when the oldest bit is 1 and the next-oldest bit is 0.
  - Exactly one detect pulse per ps2_clk fall; detection occurs 2-3 clk after the pin falls.
  - ps2_data is not synchronized separately; it is sampled on the detect cycle. PS/2 data is stable for tens of microseconds around the fall.
- Frame assembly, per detect pulse:
  - If count<10: buffer[count]<=ps2_data, count<=count+1.
  - If count==10 (11th edge, stop bit): count<=0; validate the frame.
  - Valid frame: buffer[0]==0 (start), ps2_data==1 (stop), and XOR of buffer[9:1] == 1 (odd parity over data+parity).
  - Invalid frame: silently dropped; no flag; counter still returns to 0.
  - No inter-frame timeout; bench must send whole frames.
- FIFO:
  - Circular storage with pointers of log2(FIFO_DEPTH) bits that wrap naturally.
  - empty = (w_ptr==r_ptr); full = (w_ptr+1==r_ptr).
  - Write on a valid frame:
    - if not full: store buffer[8:1] at w_ptr; w_ptr+1.
    - if full: byte dropped; overflow<=1; pointers unchanged.
  - A written byte makes ready=1 from the next clk.
- Read:
  - ready = !empty; data = storage[r_ptr].
  - When ready=1 and nextdata_n=0 at a clk edge: r_ptr+1.
  - nextdata_n=0 while empty has no effect.
  - Holding nextdata_n low pops one byte every clk.
- Simultaneous write and pop in the same clk:
  - Both occur.
  - Full is evaluated before the pop, so a write arriving while full in the same cycle as a pop is dropped and sets overflow.
- overflow stays 1 until reset; it does not block further writes once space frees.

Test Plan:
- Reset then idle (ps2_clk=ps2_data=1, 100 clk) -> ready=0, data=00, overflow=0.
- Send frame for 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1; ps2_clk period >=20 clk) -> ready=1 after 11th fall; data=1C; pulse nextdata_n low 1 clk -> ready=0.
- Send 0xF0 then 0x1C without popping -> data=F0; pop -> data=1C; pop -> ready=0.
- Send 0x1C with parity bit 1 (bad), then 0x1C with bad stop bit 0 -> ready stays 0; a following good 0x32 -> data=32.
- Send 7 bytes 01..07 with no pops -> ready=1, overflow=0; 8th byte 08 -> overflow=1, byte dropped; popping 7 times yields 01..07 then ready=0; overflow remains 1.
- Assert clrn after 5 bits of a frame, then send full frame 0x45 -> data=45, ready=1, overflow=0; nextdata_n held low with FIFO empty -> pointers unchanged.
